fetch_pc_controller: RTL and testbench
======================================

// Module: fetch_pc_controller
// PURPOSE
//  Next-PC sequencer for the fetch stage. Owns the architectural PC and drives pcNext into the FE pipeline register.
//  Arbitrates sequential increment, branch/jump redirects, hazard stalls, halt/resume and instruction-memory waits.
//  Issues fetch_req to instruction memory; flush kills wrong-path work in FE/ID.
// PARAMETERS
//  PC_W      8  PC width in bits; all PC arithmetic is modulo 2**PC_W
//  RESET_PC  0  PC value loaded on reset
//  PC_STEP   1  sequential increment per fetched instruction
//  RAS_DEPTH 4  return-stack entries (only with FETCH_RET_STACK_EN)
// PORTS
//  clock          in  1     rising-edge clock
//  reset          in  1     synchronous, active-low; reset==0 at a rising edge resets the block
//  stall          in  1     hazard stall from decode; holds PC
//  branch_taken   in  1     branch resolved taken (older instruction)
//  branch_target  in  PC_W  branch destination
//  jump           in  1     unconditional jump from decode
//  jump_target    in  PC_W  jump destination
//  halt_req       in  1     stop fetching after current access
//  resume         in  1     leave HALT
//  call           in  1     jump-and-link (used only with FETCH_RET_STACK_EN)
//  ret            in  1     return (used only with FETCH_RET_STACK_EN)
//  imem_ready     in  1     instruction memory has accepted the current access
//  pcNext         out PC_W  registered PC to FE pc input and imem address
//  fetch_req      out 1     registered; pcNext is a valid fetch address
//  flush          out 1     registered one-cycle pulse; squash FE/ID contents
//  halted         out 1     registered; state==HALT
//  ras_err        out 1     registered one-cycle pulse on stack underflow; 0 without the macro
// BEHAVIOUR
//  Reset: pcNext=RESET_PC, fetch_req=0, flush=0, halted=0, ras_err=0, state=BOOT, pending cleared, stack emptied.
//  States: BOOT, RUN, WAIT_MEM, HALT.
//   BOOT: one cycle with fetch_req=0, then RUN with fetch_req=1 at RESET_PC.
//   RUN: fetch_req=1. imem_ready=0 -> WAIT_MEM, PC held.
//   WAIT_MEM: address stable until imem_ready=1.
//   HALT: fetch_req=0, PC held; resume=1 -> RUN next cycle.
//  Per-cycle priority in RUN: halt_req > redirect > stall > increment.
//   Redirect: branch_taken beats jump. A redirect overrides stall.
//   On redirect: pcNext<=target, flush=1 the next cycle. Zero-bubble after the flush cycle.
//   Increment: imem_ready=1 and stall=0 -> pcNext<=pcNext+PC_STEP (wraps 2**PC_W-1 -> 0).
//   stall=1 without redirect: pcNext and fetch_req held.
//  WAIT_MEM redirect: target latched into a pending register and flush pulsed immediately.
//   On imem_ready=1 -> pcNext<=pending target, RUN. A later redirect overwrites the pending one.
//  halt_req in RUN -> HALT next cycle. In WAIT_MEM, it is latched and taken after imem_ready; PC advances normally first.
//  halt_req and resume together in HALT: stay in HALT. Redirects in HALT are ignored.
//  Reset low mid-WAIT_MEM or mid-HALT aborts immediately; the next cycle is BOOT.
// CONFIGURATION
//  FETCH_RET_STACK_EN defined: circular RAS_DEPTH return stack.
//   call: push pcNext+PC_STEP, redirect to jump_target.
//   ret: pop and redirect to the popped value.
//   Full push overwrites the oldest entry. ret on empty: no redirect, normal increment, ras_err pulse.
//   Priority: branch_taken > ret > call > jump.
//  Not defined: call and ret ignored, no stack storage, ras_err tied 0.
// STRUCTURE
//  fetch_pkg: state enum (BOOT/RUN/WAIT_MEM/HALT), PC_W and RESET_PC defaults, pc_t typedef.
//  Sub-module fetch_ret_stack (push/pop/empty/full), instantiated only under FETCH_RET_STACK_EN.
// TESTING
//  Reset low 2 cycles, then high with imem_ready=1 -> BOOT 1 cycle, then pcNext 0,1,2,3 with fetch_req=1.
//  pcNext=0xFF, imem_ready=1 -> next pcNext=0x00; no flush.
//  pcNext=0x10, stall=1 and branch_taken=1 with target 0x40, jump=1 with target 0x80 -> pcNext=0x40, flush=1 for 1 cycle.
//  pcNext=0x20, imem_ready=0 for 3 cycles, jump to 0x55 in cycle 2 -> pcNext stays 0x20, flush pulses;
//   on imem_ready=1 pcNext=0x55.
//  halt_req=1 at pcNext=0x05 -> halted=1, fetch_req=0, PC held; resume -> pcNext 0x05 then 0x06.
//  With macro: call at 0x10 to 0x30, then ret -> pcNext 0x30 then 0x11; second ret -> ras_err=1, pcNext increments.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch next-PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int unsigned PC_W_DEF     = 8;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef logic [PC_W_DEF-1:0] pc_t;

  // BOOT gives one idle cycle out of reset before the first fetch is issued.
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_controller_if.sv
// Control/redirect inputs and PC/fetch outputs of the fetch sequencer.
// Latency: n/a (bundle only); master = sequencer, slave = pipeline/imem side.
// Backpressure: imem_ready stalls the current fetch address.
interface fetch_pc_controller_if import fetch_pkg::*; #(
  parameter int unsigned PC_W = PC_W_DEF
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            halt_req;
  logic            resume;
  logic            call;
  logic            ret;
  logic            imem_ready;
  logic [PC_W-1:0] pcNext;
  logic            fetch_req;
  logic            flush;
  logic            halted;
  logic            ras_err;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target,
    input  halt_req, resume, call, ret, imem_ready,
    output pcNext, fetch_req, flush, halted, ras_err
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target,
    output halt_req, resume, call, ret, imem_ready,
    input  pcNext, fetch_req, flush, halted, ras_err
  );
endinterface

// File: rtl/fetch_ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Latency: push/pop take effect at the next rising edge; top_dat is combinational.
// Backpressure: none; pop on empty is ignored (caller flags the error).
// Only compiled when FETCH_RET_STACK_EN is defined.
`ifdef FETCH_RET_STACK_EN
module fetch_ret_stack #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_dat,
  output logic [PC_W-1:0] top_dat,
  output logic            empty,
  output logic            full
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] wp_q;
  logic [IDX_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q;

  // wp_q points at the next free slot; the top of stack sits just below it.
  assign top_idx = (wp_q == '0) ? IDX_W'(DEPTH - 1) : wp_q - 1'b1;
  assign top_dat = mem[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Pointer and occupancy; count saturates so overwritten entries are not counted twice.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      wp_q <= (wp_q == IDX_W'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      wp_q  <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wp_q] <= push_dat;
  end
endmodule
`endif

// File: rtl/fetch_pc_controller.sv
// Next-PC sequencer: sequential fetch, branch/jump redirects, stalls, halt/resume, imem waits.
// Latency: every output registered; a redirect lands on pcNext with flush one cycle later.
// Backpressure: imem_ready=0 holds pcNext (WAIT_MEM); stall holds pcNext unless redirected.
// Optional return stack (call/ret, ras_err) built when FETCH_RET_STACK_EN is defined.
module fetch_pc_controller import fetch_pkg::*; #(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int unsigned     PC_STEP   = 1,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset,
  fetch_pc_controller_if.master bus
);
  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_pc_q;
  logic            pend_vld_q;
  logic            halt_pend_q;
  logic            fetch_req_q;
  logic            flush_q;
  logic            halted_q;
  logic            ras_err_q;

  logic            redir;
  logic [PC_W-1:0] redir_pc;
  logic            ras_err_set;
  logic [PC_W-1:0] pc_inc;
  logic            active;

  assign pc_inc = pc_q + PC_W'(PC_STEP);
  // Redirect sources only count in WAIT_MEM, or in RUN when halt is not winning.
  assign active = (state_q == WAIT_MEM) || ((state_q == RUN) && !bus.halt_req);

`ifdef FETCH_RET_STACK_EN
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic            ras_full;
  logic [PC_W-1:0] ras_top;
  logic            unused_ras_full;

  assign unused_ras_full = ras_full;

  fetch_ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc_inc),
    .top_dat  (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  // Redirect select: branch > ret > call > jump; ret on empty stack is an error, not a redirect.
  always_comb begin
    redir       = 1'b0;
    redir_pc    = pc_q;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_err_set = 1'b0;
    if (active) begin
      if (bus.branch_taken) begin
        redir    = 1'b1;
        redir_pc = bus.branch_target;
      end else if (bus.ret) begin
        if (!ras_empty) begin
          redir    = 1'b1;
          redir_pc = ras_top;
          ras_pop  = 1'b1;
        end else begin
          ras_err_set = 1'b1;
        end
      end else if (bus.call) begin
        redir    = 1'b1;
        redir_pc = bus.jump_target;
        ras_push = 1'b1;
      end else if (bus.jump) begin
        redir    = 1'b1;
        redir_pc = bus.jump_target;
      end
    end
  end
`else
  logic [33:0] unused_ras_cfg;

  assign unused_ras_cfg = {bus.call, bus.ret, 32'(RAS_DEPTH)};
  assign ras_err_set    = 1'b0;

  // Redirect select: a resolved branch is older than a decode-stage jump.
  always_comb begin
    redir    = 1'b0;
    redir_pc = pc_q;
    if (active) begin
      if (bus.branch_taken) begin
        redir    = 1'b1;
        redir_pc = bus.branch_target;
      end else if (bus.jump) begin
        redir    = 1'b1;
        redir_pc = bus.jump_target;
      end
    end
  end
`endif

  // Sequencer FSM with registered PC, fetch_req, flush, halted and ras_err.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      pend_vld_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      fetch_req_q <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      ras_err_q   <= 1'b0;
    end else begin
      flush_q   <= 1'b0;
      ras_err_q <= ras_err_set;
      case (state_q)
        BOOT: begin
          state_q     <= RUN;
          fetch_req_q <= 1'b1;
        end
        RUN: begin
          if (bus.halt_req) begin
            state_q     <= HALT;
            fetch_req_q <= 1'b0;
            halted_q    <= 1'b1;
          end else if (redir) begin
            pc_q    <= redir_pc;
            flush_q <= 1'b1;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (!bus.imem_ready) begin
            state_q <= WAIT_MEM;
          end else begin
            pc_q <= pc_inc;
          end
        end
        WAIT_MEM: begin
          // Address stays put; wrong-path work is squashed now, target applied on accept.
          if (redir) flush_q <= 1'b1;
          if (bus.halt_req) halt_pend_q <= 1'b1;
          if (bus.imem_ready) begin
            if (redir) pc_q <= redir_pc;
            else if (pend_vld_q) pc_q <= pend_pc_q;
            else if (!bus.stall) pc_q <= pc_inc;
            pend_vld_q <= 1'b0;
            if (halt_pend_q || bus.halt_req) begin
              state_q     <= HALT;
              fetch_req_q <= 1'b0;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
            end else begin
              state_q <= RUN;
            end
          end else if (redir) begin
            pend_vld_q <= 1'b1;
            pend_pc_q  <= redir_pc;
          end
        end
        HALT: begin
          if (bus.resume && !bus.halt_req) begin
            state_q     <= RUN;
            fetch_req_q <= 1'b1;
            halted_q    <= 1'b0;
          end
        end
        default: begin
          state_q     <= BOOT;
          fetch_req_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pcNext    = pc_q;
  assign bus.fetch_req = fetch_req_q;
  assign bus.flush     = flush_q;
  assign bus.halted    = halted_q;
  assign bus.ras_err   = ras_err_q;
endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed bench for fetch_pc_controller; observed word = {pcNext, fetch_req, flush, halted, ras_err}.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: imem_ready driven directly by the scenarios.
module tb_fetch_pc_controller;
  import fetch_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic [11:0] exp;

  fetch_pc_controller_if bus ();

  fetch_pc_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] snap();
    return {bus.pcNext, bus.fetch_req, bus.flush, bus.halted, bus.ras_err};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump         = 1'b0;
    bus.halt_req     = 1'b0;
    bus.resume       = 1'b0;
    bus.call         = 1'b0;
    bus.ret          = 1'b0;
  endtask

  task automatic test_reset();
    clear_ctl();
    bus.branch_target = 8'h00;
    bus.jump_target   = 8'h00;
    bus.imem_ready    = 1'b1;
    reset = 1'b0;
    tick(); tick();
    exp = {8'h00, 4'b0000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL reset_state got %h want %h", snap(), exp); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {8'(i), 4'b1000}; n_cmp++;
      if (snap() !== exp) begin n_bad++; $display("FAIL boot_seq%0d got %h want %h", i, snap(), exp); end
    end
  endtask

  task automatic test_wrap();
    bus.jump = 1'b1; bus.jump_target = 8'hFE;
    tick(); clear_ctl();
    exp = {8'hFE, 4'b1100}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wrap_jump got %h want %h", snap(), exp); end
    tick();
    exp = {8'hFF, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wrap_ff got %h want %h", snap(), exp); end
    tick();
    exp = {8'h00, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wrap_00 got %h want %h", snap(), exp); end
  endtask

  task automatic test_redirect();
    bus.jump = 1'b1; bus.jump_target = 8'h10;
    tick(); clear_ctl();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 8'h40;
    bus.jump = 1'b1; bus.jump_target = 8'h80;
    tick(); clear_ctl();
    exp = {8'h40, 4'b1100}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL branch_prio got %h want %h", snap(), exp); end
    tick();
    exp = {8'h41, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL flush_one_cycle got %h want %h", snap(), exp); end
    bus.stall = 1'b1;
    tick(); tick();
    exp = {8'h41, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL stall_hold got %h want %h", snap(), exp); end
    bus.stall = 1'b0;
    tick();
    exp = {8'h42, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL stall_release got %h want %h", snap(), exp); end
  endtask

  task automatic test_wait_mem();
    bus.jump = 1'b1; bus.jump_target = 8'h20;
    tick(); clear_ctl();
    bus.imem_ready = 1'b0;
    tick();
    exp = {8'h20, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_hold got %h want %h", snap(), exp); end
    bus.jump = 1'b1; bus.jump_target = 8'h55;
    tick(); clear_ctl();
    exp = {8'h20, 4'b1100}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_flush got %h want %h", snap(), exp); end
    tick();
    exp = {8'h20, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_still got %h want %h", snap(), exp); end
    bus.imem_ready = 1'b1;
    tick();
    exp = {8'h55, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_pending got %h want %h", snap(), exp); end
    tick();
    exp = {8'h56, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_resume_inc got %h want %h", snap(), exp); end
    bus.imem_ready = 1'b0;
    tick();
    bus.jump = 1'b1; bus.jump_target = 8'h70;
    tick(); clear_ctl();
    bus.branch_taken = 1'b1; bus.branch_target = 8'h60;
    tick(); clear_ctl();
    tick();
    bus.imem_ready = 1'b1;
    tick();
    exp = {8'h60, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL pending_overwrite got %h want %h", snap(), exp); end
  endtask

  task automatic test_halt();
    bus.jump = 1'b1; bus.jump_target = 8'h05;
    tick(); clear_ctl();
    bus.halt_req = 1'b1;
    tick(); clear_ctl();
    exp = {8'h05, 4'b0010}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL halt_enter got %h want %h", snap(), exp); end
    bus.jump = 1'b1; bus.jump_target = 8'h99;
    tick(); clear_ctl();
    exp = {8'h05, 4'b0010}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL halt_ignore_jump got %h want %h", snap(), exp); end
    bus.halt_req = 1'b1; bus.resume = 1'b1;
    tick(); clear_ctl();
    exp = {8'h05, 4'b0010}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL halt_and_resume got %h want %h", snap(), exp); end
    bus.resume = 1'b1;
    tick(); clear_ctl();
    exp = {8'h05, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL resume_pc got %h want %h", snap(), exp); end
    tick();
    exp = {8'h06, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL resume_inc got %h want %h", snap(), exp); end
    bus.imem_ready = 1'b0;
    tick();
    bus.halt_req = 1'b1;
    tick(); clear_ctl();
    exp = {8'h06, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_halt_latched got %h want %h", snap(), exp); end
    bus.imem_ready = 1'b1;
    tick();
    exp = {8'h07, 4'b0010}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_halt_taken got %h want %h", snap(), exp); end
    bus.resume = 1'b1;
    tick(); clear_ctl();
    tick();
    exp = {8'h08, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL wait_halt_resume got %h want %h", snap(), exp); end
  endtask

  task automatic test_reset_abort();
    bus.imem_ready = 1'b0;
    tick();
    bus.jump = 1'b1; bus.jump_target = 8'h77;
    tick(); clear_ctl();
    reset = 1'b0;
    tick();
    exp = {8'h00, 4'b0000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL abort_wait got %h want %h", snap(), exp); end
    reset = 1'b1; bus.imem_ready = 1'b1;
    tick(); tick();
    exp = {8'h01, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL abort_pend_cleared got %h want %h", snap(), exp); end
    bus.halt_req = 1'b1;
    tick(); clear_ctl();
    reset = 1'b0;
    tick();
    exp = {8'h00, 4'b0000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL abort_halt got %h want %h", snap(), exp); end
    reset = 1'b1;
    tick();
    exp = {8'h00, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL abort_reboot got %h want %h", snap(), exp); end
  endtask

`ifdef FETCH_RET_STACK_EN
  task automatic test_ret_stack();
    bus.jump = 1'b1; bus.jump_target = 8'h10;
    tick(); clear_ctl();
    bus.call = 1'b1; bus.jump_target = 8'h30;
    tick(); clear_ctl();
    exp = {8'h30, 4'b1100}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL call_target got %h want %h", snap(), exp); end
    bus.ret = 1'b1;
    tick(); clear_ctl();
    exp = {8'h11, 4'b1100}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL ret_pop got %h want %h", snap(), exp); end
    bus.ret = 1'b1;
    tick(); clear_ctl();
    exp = {8'h12, 4'b1001}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL ret_underflow got %h want %h", snap(), exp); end
    tick();
    exp = {8'h13, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL ras_err_pulse got %h want %h", snap(), exp); end
  endtask
`else
  task automatic test_ret_stack();
    bus.call = 1'b1; bus.jump_target = 8'h30;
    tick(); clear_ctl();
    exp = {8'h01, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL call_ignored got %h want %h", snap(), exp); end
    bus.ret = 1'b1;
    tick(); clear_ctl();
    exp = {8'h02, 4'b1000}; n_cmp++;
    if (snap() !== exp) begin n_bad++; $display("FAIL ret_ignored got %h want %h", snap(), exp); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_wrap();
    test_redirect();
    test_wait_mem();
    test_halt();
    test_reset_abort();
    test_ret_stack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule
